// File: rtl/ic_hc_block_sequencer.sv
// Huffman-stage block sequencer: walks each 64-coefficient block through DC/AC/EOB,
// steers per-channel DC-difference and table selects, and tracks end of image.
//
// state   | meaning
// S_FETCH | waiting to read the next FIFO0 word (block start or next burst)
// S_RUN   | parallel-to-serial stage shifting coefficients out
// S_GAP   | one idle cycle after the last nonzero coefficient
// S_EOB   | emit EOB code, block end
// S_DRAIN | discard the block's unread FIFO0 words
module ic_hc_block_sequencer #(
    parameter int NUM_CH  = 3,
    parameter int MCU_LEN = 6,
    parameter int BURST   = 8,
    parameter int BLK_W   = 20,
    parameter int LVL_W   = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [BLK_W-1:0]     cfg_num_blocks,
    input  logic [3*MCU_LEN-1:0] cfg_mcu_map,
    input  logic [NUM_CH-1:0]    cfg_tbl_map,
    input  logic [LVL_W-1:0]     cfg_hi_wm,
    input  logic [LVL_W-1:0]     cfg_lo_wm,
    input  logic                 ff0_empty,
    input  logic [LVL_W-1:0]     ff0_usedw,
    input  logic                 ff1_empty,
    input  logic [5:0]           ff1_q,
    input  logic                 coef_valid,
    input  logic                 ack_pre_eoi,
    output logic                 ff0_rdreq,
    output logic                 ff1_rdreq,
    output logic                 pts_enable,
    output logic                 dc_enable,
    output logic                 ac_enable,
    output logic                 eob_enable,
    output logic [NUM_CH-1:0]    diff_enable,
    output logic [1:0]           tbl_select,
    output logic [2:0]           ch_id,
    output logic                 pre_eoi,
    output logic                 eoi,
    output logic                 ff0_wait_request
);

    typedef enum logic [2:0] {S_FETCH, S_RUN, S_GAP, S_EOB, S_DRAIN} state_t;

    localparam logic [5:0]       BMASK     = 6'(BURST - 1);
    localparam logic [6:0]       WPB       = 7'(64 / BURST);
    localparam logic [2:0]       SLOT_LAST = 3'(MCU_LEN - 1);
    localparam logic [BLK_W-1:0] BLK_ONE   = BLK_W'(1);

    state_t              state_q;
    logic [5:0]          count_q;
    logic [6:0]          burst_q;
    logic [2:0]          slot_q;
    logic [BLK_W-1:0]    blk_q;
    logic [5:0]          eob_idx_q;
    logic                pts_q;
    logic [NUM_CH-1:0]   diff_q;
    logic [1:0]          tbl_q;
    logic                wait_q;
    logic                pre_eoi_q;
    logic                eoi_q;

    logic                done;
    logic                burst_end;
    logic                tbl_bit;
    logic [NUM_CH-1:0]   ch_onehot;
    logic [2:0]          ch_id_c;
    logic [2:0]          slot_d;

    assign done      = (blk_q == cfg_num_blocks);
    assign burst_end = ((count_q & BMASK) == BMASK);
    assign slot_d    = (slot_q == SLOT_LAST) ? 3'd0 : slot_q + 3'd1;

    always_comb begin
        ch_id_c = 3'd0;
        for (int k = 0; k < MCU_LEN; k++) begin
            if (slot_q == 3'(k)) ch_id_c = cfg_mcu_map[3*k +: 3];
        end
    end

    // Out-of-range channel codes select nothing rather than aliasing a real channel.
    always_comb begin
        tbl_bit   = 1'b0;
        ch_onehot = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_id_c == 3'(c)) begin
                tbl_bit      = cfg_tbl_map[c];
                ch_onehot[c] = 1'b1;
            end
        end
    end

    assign ff0_rdreq = ((state_q == S_FETCH) & ~ff0_empty & ~done) |
                       ((state_q == S_DRAIN) & ~ff0_empty);
    assign ff1_rdreq = ff0_rdreq & (state_q == S_FETCH) & (count_q == 6'd0);

    assign dc_enable        = coef_valid & (count_q == 6'd0);
    assign ac_enable        = coef_valid & (count_q != 6'd0);
    assign eob_enable       = (state_q == S_EOB);
    assign ch_id            = ch_id_c;
    assign pts_enable       = pts_q;
    assign diff_enable      = diff_q;
    assign tbl_select       = tbl_q;
    assign pre_eoi          = pre_eoi_q;
    assign eoi              = eoi_q;
    assign ff0_wait_request = wait_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            pts_q   <= 1'b0;
            count_q <= 6'd0;
            burst_q <= 7'd0;
            slot_q  <= 3'd0;
            blk_q   <= '0;
        end else if (start) begin
            state_q <= S_FETCH;
            pts_q   <= 1'b0;
            count_q <= 6'd0;
            burst_q <= 7'd0;
            slot_q  <= 3'd0;
            blk_q   <= '0;
        end else begin
            if (coef_valid) count_q <= count_q + 6'd1;
            if (ff0_rdreq)  burst_q <= burst_q + 7'd1;
            case (state_q)
                S_FETCH: begin
                    if (ff0_rdreq) begin
                        pts_q   <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (coef_valid) begin
                        if ((count_q == eob_idx_q) && (eob_idx_q != 6'd63)) begin
                            pts_q   <= 1'b0;
                            state_q <= S_GAP;
                        end else if (count_q == 6'd63) begin
                            pts_q   <= 1'b0;
                            state_q <= S_FETCH;
                            count_q <= 6'd0;
                            burst_q <= 7'd0;
                            blk_q   <= blk_q + BLK_ONE;
                            slot_q  <= slot_d;
                        end else if (burst_end) begin
                            pts_q   <= 1'b0;
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_GAP: state_q <= S_EOB;
                S_EOB: begin
                    count_q <= 6'd0;
                    blk_q   <= blk_q + BLK_ONE;
                    slot_q  <= slot_d;
                    // The burst counter survives into DRAIN so it knows how many words remain.
                    if (burst_q == WPB) begin
                        burst_q <= 7'd0;
                        state_q <= S_FETCH;
                    end else begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (ff0_rdreq && (burst_q == WPB - 7'd1)) begin
                        burst_q <= 7'd0;
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eob_idx_q <= 6'd0;
            diff_q    <= '0;
            tbl_q     <= 2'b00;
            wait_q    <= 1'b0;
            pre_eoi_q <= 1'b0;
            eoi_q     <= 1'b0;
        end else begin
            if (ff1_rdreq) eob_idx_q <= ff1_q;
            diff_q <= ff1_rdreq ? ch_onehot : '0;
            if (dc_enable) begin
                tbl_q <= {1'b0, tbl_bit};
            end else if (ac_enable || eob_enable) begin
                tbl_q <= {1'b1, tbl_bit};
            end
            if (ff0_usedw >= cfg_hi_wm) begin
                wait_q <= 1'b1;
            end else if (ff0_usedw <= cfg_lo_wm) begin
                wait_q <= 1'b0;
            end
            if (start) begin
                pre_eoi_q <= 1'b0;
                eoi_q     <= 1'b0;
            end else begin
                if (done && ff0_empty && ff1_empty) pre_eoi_q <= 1'b1;
                if (done && ack_pre_eoi)            eoi_q     <= 1'b1;
            end
        end
    end

endmodule
